// File: rtl/seg_capture.sv
// Seven-segment display snooper: debounces multiplexed {dig_sel, seg_in} samples,
// decodes each stable digit and publishes a 4-digit frame once every digit is seen.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACC_AT  = 8'(STABLE_CYCLES - 2);

  // Segment decode: bit 4 is the invalid-pattern flag, bits 3:0 the nibble.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h67:   res = 5'h09;
      7'h00:   res = 5'h0F;
      default: res = 5'h1E;
    endcase
    return res;
  endfunction

  function automatic logic is_onehot(input logic [3:0] sel);
    logic res;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  logic [10:0] samp_r;
  logic [7:0]  cnt_r;
  logic [15:0] stage_val_r;
  logic [3:0]  stage_err_r;
  logic [3:0]  mask_r;

  logic [10:0] samp_next_s;
  logic        same_s;
  logic [7:0]  cnt_next_s;
  logic        accept_s;
  logic [4:0]  dec_s;
  logic [15:0] stage_val_s;
  logic [3:0]  stage_err_s;
  logic [3:0]  mask_s;
  logic        frame_done_s;

  assign samp_next_s = {dig_sel, seg_in};
  assign same_s      = (samp_next_s == samp_r);
  assign dec_s       = decode_seg(samp_r[6:0]);
  // Fires on the single edge where the run of identical samples reaches STABLE_CYCLES.
  assign accept_s    = same_s && (cnt_r == ACC_AT) && is_onehot(samp_r[10:7]);

  // Saturating stability counter: counts repeats of the held sample.
  always_comb begin
    cnt_next_s = cnt_r;
    if (!same_s) begin
      cnt_next_s = 8'd0;
    end else if (cnt_r < CNT_MAX) begin
      cnt_next_s = cnt_r + 8'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Merge an accepted digit into staging and the capture mask.
  always_comb begin
    stage_val_s = stage_val_r;
    stage_err_s = stage_err_r;
    mask_s      = mask_r;
    if (accept_s) begin
      for (int i = 0; i < 4; i++) begin
        stage_val_s[4*i +: 4] = samp_r[7+i] ? dec_s[3:0] : stage_val_r[4*i +: 4];
        stage_err_s[i]        = samp_r[7+i] ? dec_s[4]   : stage_err_r[i];
      end
      mask_s = mask_r | samp_r[10:7];
    end else begin
      mask_s = mask_r;
    end
  end

  assign frame_done_s = accept_s && (mask_s == 4'hF);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_r      <= 11'd0;
      cnt_r       <= 8'd0;
      stage_val_r <= 16'd0;
      stage_err_r <= 4'd0;
      mask_r      <= 4'd0;
      value       <= 16'd0;
      digit_err   <= 4'd0;
      value_valid <= 1'b0;
    end else begin
      samp_r      <= samp_next_s;
      cnt_r       <= cnt_next_s;
      stage_val_r <= stage_val_s;
      stage_err_r <= stage_err_s;
      mask_r      <= frame_done_s ? 4'd0 : mask_s;
      value_valid <= frame_done_s;
      if (frame_done_s) begin
        value     <= stage_val_s;
        digit_err <= stage_err_s;
      end else begin
        value     <= value;
        digit_err <= digit_err;
      end
    end
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical input samples required before a digit is accepted (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_in  input  7  segment pattern gfedcba, active-high, bit0 = a.
REQ-005 SHALL have port dig_sel  input  4  active-high one-hot digit enable, bit0 = rightmost digit.
REQ-006 SHALL have port value  output  16  captured frame, digit i in bits [4i+3:4i].
REQ-007 SHALL have port value_valid  output  1  one-cycle pulse when value/digit_err update.
REQ-008 SHALL have port digit_err  output  4  per-digit invalid-pattern flags for the frame in value.

Function
REQ-009 SHALL register {dig_sel, seg_in} every cycle into a sample register; all decisions use registered samples only.
REQ-010 SHALL keep a saturating stability counter: cleared when a new sample differs from the held sample, incremented otherwise.
REQ-011 SHALL accept a digit exactly once per stable window, at the edge where STABLE_CYCLES consecutive identical samples have been registered; no re-acceptance until the sample changes.
REQ-012 SHALL latency: inputs first presented before edge k and held, digit accepted at edge k+STABLE_CYCLES-1 internally; a frame-completing acceptance makes value/value_valid visible after that same edge.
REQ-013 SHALL ignore windows whose dig_sel is not one-hot (zero or multiple bits): no acceptance, mask unchanged.
REQ-014 SHALL decode patterns: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9, 00 (blank)->F; any other pattern->E with error flag set.
REQ-015 SHALL store each accepted nibble and its error flag into staging slot i for the selected digit and set capture mask bit i.
REQ-016 SHALL, on a repeat acceptance for a digit whose mask bit is already set, overwrite that staging slot (latest wins) without changing the mask.
REQ-017 SHALL, at the edge an acceptance makes the mask all ones, load value and digit_err from staging (including the nibble accepted that edge), pulse value_valid high for exactly one cycle, and clear the mask.
REQ-018 SHALL hold value and digit_err stable between value_valid pulses.
REQ-019 SHALL accept digits in any order; frame completion depends only on the mask.
REQ-020 SHALL saturate the stability counter at STABLE_CYCLES; no wrap-around under arbitrarily long holds.

Reset
REQ-021 SHALL, while rst is high at an edge, clear value, digit_err, value_valid, staging, mask, stability counter and sample register to zero.
REQ-022 SHALL discard any partial frame on reset; the first value_valid after reset requires four fresh acceptances.
REQ-023 SHALL treat the cleared sample register (dig_sel = 0) as non-one-hot, so no acceptance occurs from reset state.

Verification (STABLE_CYCLES = 4)
REQ-024 SHALL cover: dig_sel 0001/0010/0100/1000 with seg_in 06/5B/4F/66, each held 8 cycles -> one value_valid pulse, value = 16'h4321, digit_err = 0000.
REQ-025 SHALL cover: digit 0 pattern 3F held 3 cycles then changed to 06 held 2 cycles -> no acceptance, mask stays 0000, no value_valid.
REQ-026 SHALL cover: full frame with digit 2 = 7E, others 3F -> value = 16'h0E00, digit_err = 0100.
REQ-027 SHALL cover: digit 3 = 00, digits 2..0 = 3F -> value = 16'hF000, digit_err = 0000.
REQ-028 SHALL cover: dig_sel = 0011 with seg_in 06 held 10 cycles -> no acceptance, no value_valid, outputs unchanged.
REQ-029 SHALL cover: digits 0,1 accepted, rst pulsed 1 cycle, then full frame 6D/7D/07/7F -> single value_valid, value = 16'h8765, no pulse before fourth new acceptance.
